ps2_kbd_rx: RTL and testbench
=============================

PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 The block SHALL have parameter FIFO_BITS, default 3, giving log2 of the output FIFO depth (8 entries).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, giving the number of idle clk_sys cycles that abort a partial frame.
REQ-003 Port clk_sys  in  1  single clock for all logic; rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port ps2_clk  in  1  PS/2 clock line from the io controller side; idle high.
REQ-006 Port ps2_data  in  1  PS/2 data line; idle high.
REQ-007 Port rd  in  1  pop strobe; one entry is consumed per cycle while rd=1 and valid=1.
REQ-008 Port dout  out  8  received byte at the FIFO head (first-word fall-through).
REQ-009 Port valid  out  1  the FIFO is non-empty.
REQ-010 Port parity_err  out  1  one-cycle pulse when a frame arrives with bad odd parity.
REQ-011 Port frame_err  out  1  one-cycle pulse on a bad stop bit or a timeout.
REQ-012 Port overflow  out  1  one-cycle pulse when a good byte arrives while the FIFO is full.

Function
REQ-013 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is detected from the synchronized clock and its registered copy.
REQ-014 Data SHALL be sampled on the detected ps2_clk falling edge only.
REQ-015 The FSM SHALL have states IDLE, DATA, PARITY and STOP.
REQ-016 In IDLE: a sampled 0 is the start bit and moves the FSM to DATA with the bit counter at 0; a sampled 1 is ignored.
REQ-017 In DATA: 8 bits are shifted in LSB first; after the 8th bit the FSM moves to PARITY.
REQ-018 In PARITY: the parity bit is sampled; the frame is good when the eight data bits plus the parity bit contain an odd number of ones. The FSM moves to STOP.
REQ-019 In STOP the FSM SHALL always return to IDLE, then:
- stop bit 1 and good parity: push the byte;
- stop bit 1 and bad parity: pulse parity_err, no push;
- stop bit 0: pulse frame_err, no push, even if parity is also bad.
REQ-020 Pushes SHALL occur on the clk_sys edge that registers the stop sample. valid SHALL rise 3-4 clk_sys cycles after the raw ps2_clk falling edge of the stop bit.
REQ-021 Push to a full FIFO: the byte is dropped, overflow pulses, and the pointers are unchanged.
REQ-022 Push and pop in the same cycle while full: both SHALL occur and no overflow is raised.
REQ-023 rd while empty SHALL be ignored. Push and rd in the same cycle while empty: the push is kept and valid rises on the next cycle.
REQ-024 Pointers SHALL be FIFO_BITS wide with natural wrap. The occupancy counter SHALL be FIFO_BITS+1 wide.
REQ-025 dout SHALL equal the head entry whenever valid=1; it is don't-care when valid=0.

Reset
REQ-026 On reset the block SHALL:
- set the FSM to IDLE and clear the bit counter and shift register;
- empty the FIFO;
- drive valid, parity_err, frame_err and overflow to 0;
- set the synchronizer flops to 1 so that no false edge is detected.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame. The first frame whose start bit arrives after reset is released SHALL be received correctly.

Configuration
REQ-028 With PS2_RX_TIMEOUT_EN defined, a cycle counter SHALL clear on every detected falling edge and hold at 0 in IDLE.
REQ-029 With PS2_RX_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES outside IDLE, the FSM SHALL return to IDLE, pulse frame_err and discard the partial byte.
REQ-030 With PS2_RX_TIMEOUT_EN undefined, no counter SHALL exist, a stalled frame SHALL stay pending indefinitely, and TIMEOUT_CYCLES SHALL be unused.

Structure
REQ-031 Shared package ps2_pkg SHALL hold:
- the FSM state typedef;
- the constant PS2_DATA_BITS=8;
- the constant PS2_FRAME_BITS=11;
- the odd-parity reset value 1'b1 (matching the keyboard/mouse transmitter).
REQ-032 The FIFO SHALL be the sub-module ps2_rx_fifo (FIFO_BITS parameter, push/pop/full/empty). The FSM and synchronizer SHALL stay in ps2_kbd_rx.

Verification
REQ-033 Frame 0x1C, parity 0, stop 1 -> valid=1, dout=0x1C, no error pulses. rd for one cycle -> valid=0.
REQ-034 Frame 0xF0, parity 0 (bad) -> parity_err pulses once, valid stays 0. Next frame 0xF0, parity 1 -> dout=0xF0.
REQ-035 Frame 0x5A with stop bit 0 -> frame_err pulses once, no push.
REQ-036 FIFO_BITS=3, frames 0x01..0x09 with no rd -> overflow pulses on 0x09. Draining yields 0x01..0x08 in order, then valid=0.
REQ-037 PS2_RX_TIMEOUT_EN defined, TIMEOUT_CYCLES=200: start bit plus 4 data bits, then a stall of 210 cycles -> frame_err pulses. Next full frame 0x29 -> dout=0x29.
REQ-038 Reset pulsed after 5 bits of frame 0x12 -> all outputs 0, FIFO empty. Next frame 0x34 -> dout=0x34.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: FSM states and frame constants.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  // Odd parity: the running XOR starts at 1, so after the data bits it equals the expected parity bit.
  localparam logic PS2_PARITY_INIT = 1'b1;

endpackage

// File: rtl/ps2_rx_fifo.sv
// First-word fall-through byte FIFO for received PS/2 scan codes.
// Depth is 2**FIFO_BITS; a push into a full FIFO is dropped and flagged on overflow.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_BITS = 3
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     push,
  input  logic [PS2_DATA_BITS-1:0] din,
  input  logic                     pop,
  output logic [PS2_DATA_BITS-1:0] dout,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int DEPTH = 1 << FIFO_BITS;

  logic [PS2_DATA_BITS-1:0] mem [DEPTH];
  logic [FIFO_BITS-1:0]     wr_ptr_reg;
  logic [FIFO_BITS-1:0]     rd_ptr_reg;
  logic [FIFO_BITS:0]       count_reg;
  logic                     overflow_reg;
  logic                     do_push;
  logic                     do_pop;

  assign full  = (count_reg == (FIFO_BITS + 1)'(DEPTH));
  assign empty = (count_reg == '0);

  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= push & ~do_push;
      if (do_push) wr_ptr_reg <= wr_ptr_reg + FIFO_BITS'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + FIFO_BITS'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (FIFO_BITS + 1)'(1);
        2'b01:   count_reg <= count_reg - (FIFO_BITS + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  // Asynchronous read keeps the head visible in the same cycle it becomes valid.
  assign dout     = mem[rd_ptr_reg];
  assign overflow = overflow_reg;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronizer, frame FSM and output FIFO.
// Define PS2_RX_TIMEOUT_EN to abort frames stalled for TIMEOUT_CYCLES clk_sys cycles.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_BITS      = 3,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);

  localparam int CNT_W = $clog2(PS2_DATA_BITS);

  logic ps2_clk_meta_reg, ps2_clk_sync_reg, ps2_clk_prev_reg;
  logic ps2_data_meta_reg, ps2_data_sync_reg;
  logic fall;
  logic bit_in;

  ps2_state_t               state_reg, state_next;
  logic [CNT_W-1:0]         bit_cnt_reg, bit_cnt_next;
  logic [PS2_DATA_BITS-1:0] shift_reg, shift_next;
  logic                     par_acc_reg, par_acc_next;
  logic                     par_ok_reg, par_ok_next;
  logic                     parity_err_reg, parity_err_next;
  logic                     frame_err_reg, frame_err_next;
  logic                     push;
  logic                     timeout;
  logic                     fifo_empty;
  logic                     fifo_full;

  // Flops preset to 1 (idle line level) so reset release never looks like a falling edge.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ps2_clk_meta_reg  <= 1'b1;
      ps2_clk_sync_reg  <= 1'b1;
      ps2_clk_prev_reg  <= 1'b1;
      ps2_data_meta_reg <= 1'b1;
      ps2_data_sync_reg <= 1'b1;
    end else begin
      ps2_clk_meta_reg  <= ps2_clk;
      ps2_clk_sync_reg  <= ps2_clk_meta_reg;
      ps2_clk_prev_reg  <= ps2_clk_sync_reg;
      ps2_data_meta_reg <= ps2_data;
      ps2_data_sync_reg <= ps2_data_meta_reg;
    end
  end

  assign fall   = ps2_clk_prev_reg & ~ps2_clk_sync_reg;
  assign bit_in = ps2_data_sync_reg;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_reg;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tmo_cnt_reg <= '0;
    end else if (fall || state_reg == IDLE) begin
      tmo_cnt_reg <= '0;
    end else if (tmo_cnt_reg != TMO_W'(TIMEOUT_CYCLES)) begin
      tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
    end
  end

  assign timeout = (state_reg != IDLE) && !fall && (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      par_acc_reg    <= PS2_PARITY_INIT;
      par_ok_reg     <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      par_acc_reg    <= par_acc_next;
      par_ok_reg     <= par_ok_next;
      parity_err_reg <= parity_err_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    par_acc_next    = par_acc_reg;
    par_ok_next     = par_ok_reg;
    parity_err_next = 1'b0;
    frame_err_next  = 1'b0;
    push            = 1'b0;

    if (fall) begin
      case (state_reg)
        IDLE: begin
          if (!bit_in) begin
            state_next   = DATA;
            bit_cnt_next = '0;
            shift_next   = '0;
            par_acc_next = PS2_PARITY_INIT;
          end
        end
        DATA: begin
          shift_next   = {bit_in, shift_reg[PS2_DATA_BITS-1:1]};
          par_acc_next = par_acc_reg ^ bit_in;
          if (bit_cnt_reg == CNT_W'(PS2_DATA_BITS - 1)) begin
            state_next = PARITY;
          end else begin
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
        end
        PARITY: begin
          par_ok_next = (bit_in == par_acc_reg);
          state_next  = STOP;
        end
        STOP: begin
          state_next = IDLE;
          if (!bit_in)         frame_err_next  = 1'b1;
          else if (par_ok_reg) push            = 1'b1;
          else                 parity_err_next = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end else if (timeout) begin
      state_next     = IDLE;
      frame_err_next = 1'b1;
    end
  end

  ps2_rx_fifo #(
    .FIFO_BITS(FIFO_BITS)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (push),
    .din     (shift_reg),
    .pop     (rd),
    .dout    (dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .overflow(overflow)
  );

  assign valid      = ~fifo_empty;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: directed frames plus random traffic against a queue model.
// The timeout scenario runs only when PS2_RX_TIMEOUT_EN is defined.
module tb_ps2_kbd_rx;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] dout;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int perr_cnt = 0, ferr_cnt = 0, ovf_cnt = 0;
  int exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
  int lat      = 0;
  logic [7:0] q[$];

  localparam int DEPTH = 8;

  ps2_kbd_rx #(.FIFO_BITS(3), .TIMEOUT_CYCLES(200)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rd        (rd),
    .dout      (dout),
    .valid     (valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  // Cycle-count each pulse; a pulse wider than one cycle shows up as an extra count.
  always @(negedge clk_sys) begin
    if (parity_err === 1'b1) perr_cnt++;
    if (frame_err === 1'b1)  ferr_cnt++;
    if (overflow === 1'b1)   ovf_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic check_state(input string tag);
    @(negedge clk_sys);
    check({tag, ".perr"}, perr_cnt, exp_perr);
    check({tag, ".ferr"}, ferr_cnt, exp_ferr);
    check({tag, ".ovf"}, ovf_cnt, exp_ovf);
    check({tag, ".valid"}, {31'd0, valid}, {31'd0, q.size() > 0});
    if (q.size() > 0) check({tag, ".dout"}, {24'd0, dout}, {24'd0, q[0]});
  endtask

  // One PS/2 bit: data set while clock high, clock low for 8 clk_sys edges.
  // rd_edge (1..8) pulses rd across that rising clk_sys edge after the falling ps2_clk.
  task automatic ps2_bit(input logic b, input int rd_edge);
    @(negedge clk_sys);
    ps2_data = b;
    repeat (4) @(negedge clk_sys);
    ps2_clk = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i == rd_edge) rd = 1'b1;
      @(posedge clk_sys);
      #1;
      rd = 1'b0;
      if (valid === 1'b1 && lat == 0) lat = i;
    end
    @(negedge clk_sys);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk_sys);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int rd_edge, input string tag);
    bit was_empty;
    bit pushed;
    was_empty = (q.size() == 0);
    pushed    = 1'b0;
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], 0);
    ps2_bit(par, 0);
    ps2_bit(stop, rd_edge);
    if (rd_edge != 0 && q.size() > 0) void'(q.pop_front());
    if (!stop) exp_ferr++;
    else if ($countones({d, par}) % 2 == 0) exp_perr++;
    else if (q.size() == DEPTH) exp_ovf++;
    else begin
      q.push_back(d);
      pushed = 1'b1;
    end
    $display("frame %s: byte=%02h par=%0b stop=%0b rd_edge=%0d queued=%0d", tag, d, par, stop, rd_edge, q.size());
    if (was_empty && pushed) check({tag, ".latency"}, (lat >= 3 && lat <= 4) ? 32'd1 : 32'd0, 32'd1);
    check_state(tag);
  endtask

  task automatic pop_one(input string tag);
    @(negedge clk_sys);
    check({tag, ".pop_valid"}, {31'd0, valid}, 32'd1);
    if (q.size() > 0) check({tag, ".pop_dout"}, {24'd0, dout}, {24'd0, q[0]});
    rd = 1'b1;
    @(negedge clk_sys);
    rd = 1'b0;
    if (q.size() > 0) $display("pop %s: byte=%02h", tag, q.pop_front());
  endtask

  task automatic drain(input string tag);
    while (q.size() > 0) pop_one(tag);
    check_state({tag, ".drained"});
  endtask

  initial begin
    logic [7:0] d;
    logic       par;
    logic       stop;

    repeat (3) @(negedge clk_sys);
    check("reset.valid", {31'd0, valid}, 32'd0);
    check("reset.perr", {31'd0, parity_err}, 32'd0);
    check("reset.ferr", {31'd0, frame_err}, 32'd0);
    check("reset.ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk_sys);

    rd = 1'b1;
    @(negedge clk_sys);
    rd = 1'b0;
    check_state("rd_empty");

    send_frame(8'h1C, 1'b0, 1'b1, 0, "good_1c");
    pop_one("pop_1c");
    check_state("after_pop_1c");

    send_frame(8'hF0, 1'b0, 1'b1, 0, "badpar_f0");
    send_frame(8'hF0, 1'b1, 1'b1, 0, "good_f0");
    send_frame(8'h5A, odd_par(8'h5A), 1'b0, 0, "badstop_5a");
    drain("drain_a");

    for (int i = 1; i <= 9; i++) begin
      d = 8'(i);
      send_frame(d, odd_par(d), 1'b1, 0, "fill");
    end
    drain("drain_fill");

    for (int i = 0; i < DEPTH; i++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d, odd_par(d), 1'b1, 0, "refill");
    end
    send_frame(8'h77, odd_par(8'h77), 1'b1, 3, "full_push_pop");
    drain("drain_full");

    send_frame(8'h3C, odd_par(8'h3C), 1'b1, 3, "empty_push_pop");
    drain("drain_empty_pp");

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int k = $urandom_range(1, 3); k > 0 && q.size() > 0; k--) pop_one("rand_pop");
      end
      d    = 8'($urandom_range(0, 255));
      par  = ($urandom_range(0, 4) == 0) ? ~odd_par(d) : odd_par(d);
      stop = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
      send_frame(d, par, stop, 0, "random");
    end
    drain("drain_rand");

    send_frame(8'hAB, odd_par(8'hAB), 1'b1, 0, "pre_reset");
    d = 8'h12;
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) ps2_bit(d[i], 0);
    @(negedge clk_sys);
    reset = 1'b1;
    q.delete();
    repeat (2) @(negedge clk_sys);
    check("midreset.valid", {31'd0, valid}, 32'd0);
    check("midreset.perr", {31'd0, parity_err}, 32'd0);
    check("midreset.ferr", {31'd0, frame_err}, 32'd0);
    check("midreset.ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_state("after_reset");
    send_frame(8'h34, odd_par(8'h34), 1'b1, 0, "post_reset_34");
    drain("drain_reset");

`ifdef PS2_RX_TIMEOUT_EN
    d = 8'h6E;
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) ps2_bit(d[i], 0);
    repeat (210) @(negedge clk_sys);
    exp_ferr++;
    $display("stall: partial frame abandoned");
    check_state("timeout");
    send_frame(8'h29, odd_par(8'h29), 1'b1, 0, "post_timeout_29");
    drain("drain_timeout");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
